// File: rtl/rom_sweep_pkg.sv
// rom_sweep_pkg: shared state encoding and default widths for the ROM address sequencer
package rom_sweep_pkg;
  localparam int ROM_SWEEP_ADDR_W = 4;
  localparam int ROM_SWEEP_DATA_W = 4;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} rom_sweep_state_t;
endpackage

// File: rtl/rom_sweep_csum.sv
// rom_sweep_csum: running XOR of transferred words (clear wins over en); ports clk, rst_n, clear, en, din -> csum
module rom_sweep_csum #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] csum
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (clear) csum <= '0;
    else if (en) csum <= csum ^ din;
endmodule

// File: rtl/rom_sweep.sv
// rom_sweep: sweeps consecutive ROM addresses and streams each registered word over valid/ready; ports start/start_addr/count in, rom_addr/rom_data to the ROM, out_data/out_valid/out_ready stream, busy/done status, csum only with ROM_SWEEP_CHECKSUM_EN
module rom_sweep
  import rom_sweep_pkg::*;
#(
  parameter int ADDR_W = ROM_SWEEP_ADDR_W,
  parameter int DATA_W = ROM_SWEEP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef ROM_SWEEP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);
  rom_sweep_state_t state, state_n;
  logic [ADDR_W:0] remaining;
  logic            accept, xfer, last;
  assign accept = (state == IDLE) && start;
  assign xfer   = out_valid && out_ready;
  assign last   = remaining == (ADDR_W+1)'(1);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)  ? (start ? ((count == '0) ? DONE : FETCH) : IDLE)
            : (state == FETCH) ? HOLD
            : (state == HOLD)  ? (xfer ? (last ? DONE : FETCH) : HOLD)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= state_n == DONE;
      if (accept) begin
        rom_addr  <= start_addr;
        remaining <= count;
        busy      <= 1'b1;
      end
      if (state == FETCH) begin
        out_data  <= rom_data;
        out_valid <= 1'b1;
      end
      if (state == HOLD && xfer) begin
        out_valid <= 1'b0;
        remaining <= remaining - 1'b1;
        if (!last) rom_addr <= rom_addr + 1'b1;
      end
      if (state == DONE) busy <= 1'b0;
    end
`ifdef ROM_SWEEP_CHECKSUM_EN
  rom_sweep_csum #(.DATA_W(DATA_W)) u_csum (
    .clk(clk), .rst_n(rst_n), .clear(accept), .en(xfer), .din(out_data), .csum(csum)
  );
`endif
endmodule

// File: tb/tb_rom_sweep.sv
// tb_rom_sweep: directed table-driven bench with an inverting ROM (data = 15 - address)
module tb_rom_sweep;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [3:0] start_addr = '0, rom_addr, rom_data, out_data;
  logic [4:0] count = '0;
  logic       out_valid, busy, done;
`ifdef ROM_SWEEP_CHECKSUM_EN
  logic [3:0] csum;
`endif
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign rom_data = 4'hF - rom_addr;

  rom_sweep dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
`ifdef ROM_SWEEP_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  typedef struct {
    logic [3:0] sa;
    logic [4:0] cnt;
    int         stall;
    bit         poke;
    logic [3:0] first;
    logic [3:0] last;
    int         done_k;
    logic [3:0] cs;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int k = 0, words = 0, first_k = -1, done_k = -1, stalled = 0;
    bit saw_valid = 0;
    logic [3:0] got_first = '0, got_last = '0, ea;
    @(negedge clk);
    start = 1'b1; start_addr = v.sa; count = v.cnt; out_ready = 1'b1;
    while (done_k < 0 && k < 200) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (v.poke && k == 3) begin
        start = 1'b1; start_addr = 4'd9; count = 5'd2;
      end
      if (k == 1) chk("busy_after_start", busy, 1);
      ea = v.sa + 4'(words);
      if (out_valid) begin
        saw_valid = 1;
        if (first_k < 0) first_k = k;
        chk("word_addr", rom_addr, ea);
        chk("word_data", out_data, 4'hF - ea);
      end
      out_ready = !(out_valid && words == 0 && stalled < v.stall);
      if (out_valid && !out_ready) stalled++;
      if (out_valid && out_ready) begin
        if (words == 0) got_first = out_data;
        got_last = out_data;
        words++;
      end
      if (done) begin
        done_k = k;
        chk("busy_during_done", busy, 1);
`ifdef ROM_SWEEP_CHECKSUM_EN
        chk("csum_at_done", csum, v.cs);
`endif
      end
    end
    start = 1'b0;
    chk("done_cycle", done_k, v.done_k);
    chk("word_count", words, v.cnt);
    if (v.cnt != 0) begin
      chk("first_valid_cycle", first_k, 2);
      chk("first_word", got_first, v.first);
      chk("last_word", got_last, v.last);
    end else chk("empty_no_valid", saw_valid, 0);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("busy_after_done", busy, 0);
    chk("valid_after_done", out_valid, 0);
`ifdef ROM_SWEEP_CHECKSUM_EN
    chk("csum_stable", csum, v.cs);
`endif
  endtask

  initial begin
    tbl[0] = '{4'd0,  5'd3,  0, 1'b0, 4'hF, 4'hD, 7,  4'hC};
    tbl[1] = '{4'd14, 5'd4,  0, 1'b0, 4'h1, 4'hE, 9,  4'h0};
    tbl[2] = '{4'd0,  5'd3,  5, 1'b0, 4'hF, 4'hD, 12, 4'hC};
    tbl[3] = '{4'd3,  5'd0,  0, 1'b0, 4'h0, 4'h0, 1,  4'h0};
    tbl[4] = '{4'd0,  5'd3,  0, 1'b1, 4'hF, 4'hD, 7,  4'hC};
    tbl[5] = '{4'd0,  5'd16, 0, 1'b0, 4'hF, 4'h0, 33, 4'h0};
    tbl[6] = '{4'd5,  5'd1,  0, 1'b0, 4'hA, 4'hA, 3,  4'hA};
    repeat (2) @(negedge clk);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run(tbl[i]);
    @(negedge clk);
    start = 1'b1; start_addr = 4'd3; count = 5'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rom_addr", rom_addr, 0);
    chk("midrun_out_data", out_data, 0);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_done", done, 0);
`ifdef ROM_SWEEP_CHECKSUM_EN
    chk("midrun_csum", csum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run(tbl[6]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
